// File: rtl/csr_mem_bridge_mb.sv
// csr_mem_bridge_mb: bridges single-word CSR reads/writes onto NUM_BANKS
// word-interleaved single-port RAM banks with a fixed read latency.
// Optional feature macro: CSR_MEM_BRIDGE_MB_RMW_EN. When it is defined, a
// write whose bit enables do not cover whole bytes is done as a
// read-modify-write. When it is undefined, such a write falls back to a
// byte-enable write, using the OR of the bit enables in each byte.
module csr_mem_bridge_mb #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int NUM_BANKS           = 4,
    parameter int BANK_DEPTH          = 8,
    parameter int BYTE_ADDR_BIT_WIDTH = 16,
    parameter int RAM_RD_LATENCY      = 2
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_sync_rst_n,
    input  logic                                                 i_req,
    input  logic                                                 i_req_is_wr,
    input  logic [BYTE_ADDR_BIT_WIDTH-1:0]                       i_byte_addr,
    input  logic [WORD_BIT_WIDTH-1:0]                            i_wr_data,
    input  logic [WORD_BIT_WIDTH-1:0]                            i_wr_bit_en,
    output logic                                                 o_rd_ack,
    output logic                                                 o_wr_ack,
    output logic [WORD_BIT_WIDTH-1:0]                            o_rd_data,
    output logic                                                 o_oor,
    output logic [NUM_BANKS-1:0]                                 o_ram_we,
    output logic [((BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1)-1:0] o_ram_word_addr,
    output logic [WORD_BIT_WIDTH-1:0]                            o_ram_wr_data,
    output logic [WORD_BIT_WIDTH/8-1:0]                          o_ram_wr_byte_en,
    input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0]                  i_ram_rd_data
);

    localparam int BYTES     = WORD_BIT_WIDTH / 8;
    localparam int OFF_BITS  = $clog2(BYTES);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BW        = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int DW        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam int TOTAL     = NUM_BANKS * BANK_DEPTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RMW_RD_WAIT,
        S_RMW_WR,
        S_ACK
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [BW-1:0]                 r_bank;
    logic                          r_is_rd;
    logic [1:0]                    r_cnt;

    logic [BYTE_ADDR_BIT_WIDTH-1:0] w_word_addr;
    logic [BW-1:0]                 w_bank;
    logic [DW-1:0]                 w_bank_word_addr;
    logic                          w_oor;
    logic                          w_accept;
    logic                          w_wait_done;
    logic                          w_no_en;
    logic                          w_direct_wr;
    logic [BYTES-1:0]              w_byte_en;
    logic [NUM_BANKS-1:0]          w_we_new;
    logic [WORD_BIT_WIDTH-1:0]     w_bank_rd;

    logic                          w_rd_ack_nxt;
    logic                          w_wr_ack_nxt;
    logic                          w_oor_nxt;
    logic [NUM_BANKS-1:0]          w_ram_we_nxt;
    logic [DW-1:0]                 w_ram_addr_nxt;
    logic [WORD_BIT_WIDTH-1:0]     w_ram_wd_nxt;
    logic [BYTES-1:0]              w_ram_be_nxt;
    logic [WORD_BIT_WIDTH-1:0]     w_rd_data_nxt;

`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
    logic [WORD_BIT_WIDTH-1:0]     r_wdata;
    logic [WORD_BIT_WIDTH-1:0]     r_bit_en;
    logic                          w_byte_gran;
    logic [NUM_BANKS-1:0]          w_we_held;
    logic [WORD_BIT_WIDTH-1:0]     w_merge;
`endif

    // Address decode: word index, interleaved bank, word within bank.
    assign w_word_addr      = i_byte_addr >> OFF_BITS;
    assign w_bank           = BW'(w_word_addr & BYTE_ADDR_BIT_WIDTH'(NUM_BANKS - 1));
    assign w_bank_word_addr = DW'((w_word_addr >> BANK_BITS) & BYTE_ADDR_BIT_WIDTH'(BANK_DEPTH - 1));
    assign w_oor            = ({1'b0, w_word_addr} >= (BYTE_ADDR_BIT_WIDTH + 1)'(TOTAL));

    assign w_accept    = (r_state == S_IDLE) && i_req;
    assign w_wait_done = (r_cnt == 2'(RAM_RD_LATENCY - 1));
    assign w_no_en     = ~|i_wr_bit_en;

    // A byte is enabled if any of its bit enables is set.
    always_comb begin
        w_byte_en = '0;
        for (int b = 0; b < BYTES; b++) begin
            w_byte_en[b] = |i_wr_bit_en[b*8 +: 8];
        end
    end

    // Bank one-hot for a new request, and read-data mux for the held bank.
    always_comb begin
        w_we_new  = '0;
        w_bank_rd = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_we_new[b] = (w_bank == BW'(b));
            if (r_bank == BW'(b)) begin
                w_bank_rd = i_ram_rd_data[b*WORD_BIT_WIDTH +: WORD_BIT_WIDTH];
            end
        end
    end

`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
    // A write is byte-granular when every byte is either fully on or fully off.
    always_comb begin
        w_byte_gran = 1'b1;
        for (int b = 0; b < BYTES; b++) begin
            if ((|i_wr_bit_en[b*8 +: 8]) && !(&i_wr_bit_en[b*8 +: 8])) begin
                w_byte_gran = 1'b0;
            end
        end
    end

    // Merge the old word with the new data under the bit mask.
    always_comb begin
        w_we_held = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_we_held[b] = (r_bank == BW'(b));
        end
        w_merge = (w_bank_rd & ~r_bit_en) | (r_wdata & r_bit_en);
    end

    assign w_direct_wr = w_byte_gran;
`else
    assign w_direct_wr = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) r_state <= S_IDLE;
        else               r_state <= w_state_nxt;
    end

    // FSM next state. Out-of-range and no-enable writes finish straight from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req && !w_oor) begin
                    if (!i_req_is_wr)     w_state_nxt = S_RD_WAIT;
                    else if (w_no_en)     w_state_nxt = S_IDLE;
                    else if (w_direct_wr) w_state_nxt = S_ACK;
                    else                  w_state_nxt = S_RMW_RD_WAIT;
                end
            end
            S_RD_WAIT:     if (w_wait_done) w_state_nxt = S_ACK;
            S_RMW_RD_WAIT: if (w_wait_done) w_state_nxt = S_RMW_WR;
            S_RMW_WR:      w_state_nxt = S_ACK;
            S_ACK:         w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: next values for the output registers. RAM address, data and
    // byte enables hold between accesses; the write enable and the acks are pulses.
    always_comb begin
        w_rd_ack_nxt   = 1'b0;
        w_wr_ack_nxt   = 1'b0;
        w_oor_nxt      = 1'b0;
        w_ram_we_nxt   = '0;
        w_ram_addr_nxt = o_ram_word_addr;
        w_ram_wd_nxt   = o_ram_wr_data;
        w_ram_be_nxt   = o_ram_wr_byte_en;
        w_rd_data_nxt  = o_rd_data;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_oor) begin
                        w_oor_nxt    = 1'b1;
                        w_rd_ack_nxt = ~i_req_is_wr;
                        w_wr_ack_nxt = i_req_is_wr;
                        if (!i_req_is_wr) w_rd_data_nxt = '0;
                    end else begin
                        w_ram_addr_nxt = w_bank_word_addr;
                        if (i_req_is_wr) begin
                            w_ram_wd_nxt = i_wr_data;
                            w_ram_be_nxt = w_byte_en;
                            if (w_no_en)          w_wr_ack_nxt = 1'b1;
                            else if (w_direct_wr) w_ram_we_nxt = w_we_new;
                        end
                    end
                end
            end
`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
            S_RMW_WR: begin
                w_ram_we_nxt = w_we_held;
                w_ram_wd_nxt = w_merge;
                w_ram_be_nxt = '1;
            end
`endif
            S_ACK: begin
                if (r_is_rd) begin
                    w_rd_ack_nxt  = 1'b1;
                    w_rd_data_nxt = w_bank_rd;
                end else begin
                    w_wr_ack_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            o_rd_ack         <= 1'b0;
            o_wr_ack         <= 1'b0;
            o_oor            <= 1'b0;
            o_ram_we         <= '0;
            o_ram_word_addr  <= '0;
            o_ram_wr_data    <= '0;
            o_ram_wr_byte_en <= '0;
            o_rd_data        <= '0;
        end else begin
            o_rd_ack         <= w_rd_ack_nxt;
            o_wr_ack         <= w_wr_ack_nxt;
            o_oor            <= w_oor_nxt;
            o_ram_we         <= w_ram_we_nxt;
            o_ram_word_addr  <= w_ram_addr_nxt;
            o_ram_wr_data    <= w_ram_wd_nxt;
            o_ram_wr_byte_en <= w_ram_be_nxt;
            o_rd_data        <= w_rd_data_nxt;
        end
    end

    // Per-request context: target bank, direction, latency counter, RMW operands.
    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            r_bank   <= '0;
            r_is_rd  <= 1'b0;
            r_cnt    <= '0;
`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
            r_wdata  <= '0;
            r_bit_en <= '0;
`endif
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_state == S_RD_WAIT || r_state == S_RMW_RD_WAIT) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_accept) begin
                r_bank   <= w_bank;
                r_is_rd  <= ~i_req_is_wr;
`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
                r_wdata  <= i_wr_data;
                r_bit_en <= i_wr_bit_en;
`endif
            end
        end
    end

endmodule

// File: tb/tb_csr_mem_bridge_mb.sv
// Directed bench for csr_mem_bridge_mb: a default-parameter instance (u0)
// and a single-bank, latency-1 instance (u1), each with a behavioural RAM.
module tb_csr_mem_bridge_mb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic ram_clr;
    int   total = 0;
    int   bad   = 0;

    // u0: 32-bit words, 4 banks x 8, latency 2
    logic         req, is_wr;
    logic [15:0]  addr;
    logic [31:0]  wd, be;
    logic         rd_ack, wr_ack, oor;
    logic [31:0]  rd_data;
    logic [3:0]   ram_we;
    logic [2:0]   ram_addr;
    logic [31:0]  ram_wd;
    logic [3:0]   ram_be;
    logic [127:0] ram_rd;

    // u1: 32-bit words, 1 bank x 8, latency 1
    logic         req1, is_wr1;
    logic [15:0]  addr1;
    logic [31:0]  wd1, be1;
    logic         rd_ack1, wr_ack1, oor1;
    logic [31:0]  rd_data1;
    logic [0:0]   ram_we1;
    logic [2:0]   ram_addr1;
    logic [31:0]  ram_wd1;
    logic [3:0]   ram_be1;
    logic [31:0]  ram_rd1;

    csr_mem_bridge_mb #(.WORD_BIT_WIDTH(32), .NUM_BANKS(4), .BANK_DEPTH(8),
                        .BYTE_ADDR_BIT_WIDTH(16), .RAM_RD_LATENCY(2)) u0 (
        .i_clk(clk), .i_sync_rst_n(rst_n), .i_req(req), .i_req_is_wr(is_wr),
        .i_byte_addr(addr), .i_wr_data(wd), .i_wr_bit_en(be),
        .o_rd_ack(rd_ack), .o_wr_ack(wr_ack), .o_rd_data(rd_data), .o_oor(oor),
        .o_ram_we(ram_we), .o_ram_word_addr(ram_addr), .o_ram_wr_data(ram_wd),
        .o_ram_wr_byte_en(ram_be), .i_ram_rd_data(ram_rd));

    csr_mem_bridge_mb #(.WORD_BIT_WIDTH(32), .NUM_BANKS(1), .BANK_DEPTH(8),
                        .BYTE_ADDR_BIT_WIDTH(16), .RAM_RD_LATENCY(1)) u1 (
        .i_clk(clk), .i_sync_rst_n(rst_n), .i_req(req1), .i_req_is_wr(is_wr1),
        .i_byte_addr(addr1), .i_wr_data(wd1), .i_wr_bit_en(be1),
        .o_rd_ack(rd_ack1), .o_wr_ack(wr_ack1), .o_rd_data(rd_data1), .o_oor(oor1),
        .o_ram_we(ram_we1), .o_ram_word_addr(ram_addr1), .o_ram_wr_data(ram_wd1),
        .o_ram_wr_byte_en(ram_be1), .i_ram_rd_data(ram_rd1));

    // Behavioural banked RAMs: byte-enable write, registered read pipeline.
    logic [31:0] mem0 [4][8];
    logic [31:0] s1_0 [4];
    logic [31:0] s2_0 [4];
    logic [31:0] mem1 [8];
    logic [31:0] s1_1;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            s1_0[b] <= mem0[b][ram_addr];
            s2_0[b] <= s1_0[b];
            for (int w = 0; w < 8; w++) begin
                if (ram_clr) begin
                    mem0[b][w] <= 32'h0;
                end else if (ram_we[b] && ram_addr == 3'(w)) begin
                    for (int k = 0; k < 4; k++)
                        if (ram_be[k]) mem0[b][w][k*8 +: 8] <= ram_wd[k*8 +: 8];
                end
            end
        end
        s1_1 <= mem1[ram_addr1];
        for (int w = 0; w < 8; w++) begin
            if (ram_clr) begin
                mem1[w] <= 32'h0;
            end else if (ram_we1[0] && ram_addr1 == 3'(w)) begin
                for (int k = 0; k < 4; k++)
                    if (ram_be1[k]) mem1[w][k*8 +: 8] <= ram_wd1[k*8 +: 8];
            end
        end
    end

    always_comb begin
        ram_rd = '0;
        for (int b = 0; b < 4; b++) ram_rd[b*32 +: 32] = s2_0[b];
        ram_rd1 = s1_1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one request for cycle T; returns in cycle T+1.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [31:0] e);
        req = 1'b1; is_wr = w; addr = a; wd = d; be = e;
        tick();
        req = 1'b0;
    endtask

    task automatic issue1(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [31:0] e);
        req1 = 1'b1; is_wr1 = w; addr1 = a; wd1 = d; be1 = e;
        tick();
        req1 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ram_clr = 1'b1;
        req = 1'b0; is_wr = 1'b0; addr = '0; wd = '0; be = '0;
        req1 = 1'b0; is_wr1 = 1'b0; addr1 = '0; wd1 = '0; be1 = '0;
        tick(); tick();
        ram_clr = 1'b0;

        // Reset state
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_oor", oor, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wd", ram_wd, 0);
        chk("rst_be", ram_be, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_we1", ram_we1, 0);
        rst_n = 1'b1;

        // Full-word write to 0x14: word 5 -> bank 1, bank word 1
        issue(1'b1, 16'h0014, 32'hDEADBEEF, 32'hFFFFFFFF);
        chk("wr_t1_we", ram_we, 4'b0010);
        chk("wr_t1_addr", ram_addr, 1);
        chk("wr_t1_be", ram_be, 4'hF);
        chk("wr_t1_wd", ram_wd, 32'hDEADBEEF);
        chk("wr_t1_ack", wr_ack, 0);
        tick();
        chk("wr_t2_ack", wr_ack, 1);
        chk("wr_t2_we", ram_we, 0);
        tick();
        chk("wr_t3_ack", wr_ack, 0);

        // Read it back: ack at T+4
        issue(1'b0, 16'h0014, 32'h0, 32'h0);
        chk("rd_t1_we", ram_we, 0);
        chk("rd_t1_addr", ram_addr, 1);
        chk("rd_t1_ack", rd_ack, 0);
        tick();
        chk("rd_t2_ack", rd_ack, 0);
        tick();
        chk("rd_t3_ack", rd_ack, 0);
        tick();
        chk("rd_t4_ack", rd_ack, 1);
        chk("rd_t4_data", rd_data, 32'hDEADBEEF);
        chk("rd_t4_oor", oor, 0);
        tick();
        chk("rd_t5_ack", rd_ack, 0);
        chk("rd_t5_hold", rd_data, 32'hDEADBEEF);

        // Byte-granular partial write to 0x1C: word 7 -> bank 3, bank word 1
        issue(1'b1, 16'h001C, 32'h12345678, 32'h00FF00FF);
        chk("bw_t1_we", ram_we, 4'b1000);
        chk("bw_t1_addr", ram_addr, 1);
        chk("bw_t1_be", ram_be, 4'b0101);
        tick();
        chk("bw_t2_ack", wr_ack, 1);
        tick();
        issue(1'b0, 16'h001C, 32'h0, 32'h0);
        tick(); tick(); tick();
        chk("bw_rd_ack", rd_ack, 1);
        chk("bw_rd_data", rd_data, 32'h00340078);
        tick();

        // Write with no bit enables: immediate ack, no RAM write
        issue(1'b1, 16'h0000, 32'hFFFFFFFF, 32'h0);
        chk("ne_t1_ack", wr_ack, 1);
        chk("ne_t1_we", ram_we, 0);
        chk("ne_t1_oor", oor, 0);
        tick();
        chk("ne_t2_ack", wr_ack, 0);
        chk("ne_t2_we", ram_we, 0);

        // Sub-byte write to 0x20 (word 8 -> bank 0, bank word 2) over 0xFFFFFFFF
        issue(1'b1, 16'h0020, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("pre_t1_we", ram_we, 4'b0001);
        chk("pre_t1_addr", ram_addr, 2);
        tick(); tick();
        issue(1'b1, 16'h0020, 32'h00000000, 32'h000000F0);
`ifdef CSR_MEM_BRIDGE_MB_RMW_EN
        chk("rmw_t1_we", ram_we, 0);
        chk("rmw_t1_ack", wr_ack, 0);
        tick(); tick();
        chk("rmw_t3_we", ram_we, 0);
        tick();
        chk("rmw_t4_we", ram_we, 4'b0001);
        chk("rmw_t4_wd", ram_wd, 32'hFFFFFF0F);
        chk("rmw_t4_be", ram_be, 4'hF);
        chk("rmw_t4_ack", wr_ack, 0);
        tick();
        chk("rmw_t5_ack", wr_ack, 1);
        chk("rmw_t5_we", ram_we, 0);
        tick();
        issue(1'b0, 16'h0020, 32'h0, 32'h0);
        tick(); tick(); tick();
        chk("rmw_rd_ack", rd_ack, 1);
        chk("rmw_rd_data", rd_data, 32'hFFFFFF0F);
`else
        chk("nrmw_t1_we", ram_we, 4'b0001);
        chk("nrmw_t1_be", ram_be, 4'b0001);
        chk("nrmw_t1_wd", ram_wd, 32'h0);
        tick();
        chk("nrmw_t2_ack", wr_ack, 1);
        tick();
        issue(1'b0, 16'h0020, 32'h0, 32'h0);
        tick(); tick(); tick();
        chk("nrmw_rd_ack", rd_ack, 1);
        chk("nrmw_rd_data", rd_data, 32'hFFFFFF00);
`endif
        tick();

        // Out-of-range read 0x80 (word 32): ack at T+1, data forced to 0
        issue(1'b0, 16'h0080, 32'h0, 32'h0);
        chk("oor_rd_ack", rd_ack, 1);
        chk("oor_rd_oor", oor, 1);
        chk("oor_rd_data", rd_data, 0);
        chk("oor_rd_we", ram_we, 0);
        tick();
        chk("oor_t2_ack", rd_ack, 0);
        chk("oor_t2_oor", oor, 0);

        // Out-of-range write: no RAM write
        issue(1'b1, 16'hFFFC, 32'h55555555, 32'hFFFFFFFF);
        chk("oorw_ack", wr_ack, 1);
        chk("oorw_oor", oor, 1);
        chk("oorw_we", ram_we, 0);
        chk("oorw_rdack", rd_ack, 0);
        tick();

        // Last in-range word 0x7C (word 31 -> bank 3, bank word 7)
        issue(1'b0, 16'h007C, 32'h0, 32'h0);
        chk("last_t1_addr", ram_addr, 7);
        chk("last_t1_ack", rd_ack, 0);
        tick(); tick(); tick();
        chk("last_ack", rd_ack, 1);
        chk("last_oor", oor, 0);
        chk("last_data", rd_data, 0);
        tick();

        // Reset during a read at T+2 aborts it; next request right after release
        issue(1'b0, 16'h0014, 32'h0, 32'h0);
        tick();
        rst_n = 1'b0;
        tick();
        chk("ra_ack", rd_ack, 0);
        chk("ra_data", rd_data, 0);
        rst_n = 1'b1;
        issue(1'b0, 16'h0014, 32'h0, 32'h0);
        chk("ra_t1_ack", rd_ack, 0);
        tick();
        chk("ra_t2_ack", rd_ack, 0);
        tick();
        chk("ra_t3_ack", rd_ack, 0);
        tick();
        chk("ra_t4_ack", rd_ack, 1);
        chk("ra_t4_data", rd_data, 32'hDEADBEEF);
        tick();

        // u1: single bank, latency 1
        issue1(1'b1, 16'h0008, 32'hA5A5A5A5, 32'hFFFFFFFF);
        chk("u1_wr_we", ram_we1, 1'b1);
        chk("u1_wr_addr", ram_addr1, 2);
        tick();
        chk("u1_wr_ack", wr_ack1, 1);
        tick();
        req1 = 1'b1; is_wr1 = 1'b0; addr1 = 16'h0008;
        tick();
        addr1 = 16'h0000;                // held request while busy
        chk("u1_rd_t1_ack", rd_ack1, 0);
        tick();
        chk("u1_rd_t2_ack", rd_ack1, 0);
        req1 = 1'b0;
        tick();
        chk("u1_rd_t3_ack", rd_ack1, 1);
        chk("u1_rd_t3_data", rd_data1, 32'hA5A5A5A5);
        tick();
        chk("u1_rd_t4_ack", rd_ack1, 0);
        tick();
        chk("u1_rd_t5_ack", rd_ack1, 0);
        chk("u1_rd_t5_hold", rd_data1, 32'hA5A5A5A5);

        issue1(1'b0, 16'h0020, 32'h0, 32'h0);
        chk("u1_oor_ack", rd_ack1, 1);
        chk("u1_oor_oor", oor1, 1);
        chk("u1_oor_data", rd_data1, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_mem_bridge_mb.md
CSR_MEM_BRIDGE_MB -- requirements
Module: csr_mem_bridge_mb

Interface
REQ-001 SHALL have parameter WORD_BIT_WIDTH, default 32, data word width; power of 2, >= 8.
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of single-port RAM banks; power of 2, >= 1.
REQ-003 SHALL have parameter BANK_DEPTH, default 8, words per bank; power of 2.
REQ-004 SHALL have parameter BYTE_ADDR_BIT_WIDTH, default 16, CSR byte address width; >= log2(NUM_BANKS*BANK_DEPTH*WORD_BIT_WIDTH/8).
REQ-005 SHALL have parameter RAM_RD_LATENCY, default 2, cycles from RAM address to read data; 1 or 2.
REQ-006 SHALL have the following ports: i_clk  in  1  clock.
REQ-007 i_sync_rst_n  in  1  one clock; reset synchronous, active-low.
REQ-008 i_req  in  1  CSR access request pulse.
REQ-009 i_req_is_wr  in  1  1 = write, 0 = read.
REQ-010 i_byte_addr  in  BYTE_ADDR_BIT_WIDTH  CSR byte address.
REQ-011 i_wr_data, i_wr_bit_en  in  WORD_BIT_WIDTH each  write data, bit enables.
REQ-012 o_rd_ack, o_wr_ack  out  1 each  completion pulses.
REQ-013 o_rd_data  out  WORD_BIT_WIDTH  read data, valid with o_rd_ack.
REQ-014 o_oor  out  1  out-of-range flag, valid with either ack.
REQ-015 o_ram_we  out  NUM_BANKS  per-bank write enable.
REQ-016 o_ram_word_addr  out  log2(BANK_DEPTH)  word address, shared by all banks.
REQ-017 o_ram_wr_data, o_ram_wr_byte_en  out  WORD_BIT_WIDTH, WORD_BIT_WIDTH/8  shared write data/byte enables.
REQ-018 i_ram_rd_data  in  NUM_BANKS*WORD_BIT_WIDTH  bank b read data at slice b.

Function
REQ-019 Word address = i_byte_addr >> log2(WORD_BIT_WIDTH/8); bank = word address mod NUM_BANKS (interleaved); bank word address = (word address / NUM_BANKS) mod BANK_DEPTH.
REQ-020 Address SHALL be out-of-range when word address >= NUM_BANKS*BANK_DEPTH; no RAM access, ack at T+1, o_oor=1, o_rd_data=0.
REQ-021 FSM states IDLE, RD_WAIT, RMW_RD_WAIT, RMW_WR, ACK; request accepted only in IDLE at cycle T; i_req outside IDLE ignored.
REQ-022 Read: RAM address registered at T+1; bank data sampled at T+1+RAM_RD_LATENCY; o_rd_ack and o_rd_data registered at T+2+RAM_RD_LATENCY.
REQ-023 Byte-granular write (each byte's bit enables all 0 or all 1): o_ram_we[bank]=1 for one cycle at T+1, o_ram_wr_byte_en = per-byte OR of bit enables; o_wr_ack at T+2.
REQ-024 Write with all bit enables 0: no RAM write; o_wr_ack at T+1.
REQ-025 o_ram_we SHALL be one-hot or zero; all outputs registered; acks are single-cycle pulses; o_rd_data holds until next read ack.

Reset
REQ-026 While i_sync_rst_n=0 at a rising edge: FSM -> IDLE; o_rd_ack, o_wr_ack, o_oor, o_ram_we, o_ram_word_addr, o_ram_wr_data, o_ram_wr_byte_en, o_rd_data = 0.
REQ-027 Reset mid-operation SHALL abort the access with no ack and no RAM write; first request accepted in first cycle after release.

Configuration
REQ-028 Macro CSR_MEM_BRIDGE_MB_RMW_EN defined: non-byte-granular write performs read-modify-write: RAM read at T+1, merge new = (old & ~bit_en) | (wr_data & bit_en) at T+1+RAM_RD_LATENCY, full-word write at T+2+RAM_RD_LATENCY, o_wr_ack at T+3+RAM_RD_LATENCY.
REQ-029 Macro undefined: non-byte-granular write treated as REQ-023 (byte enable = OR of bit enables); RMW_RD_WAIT/RMW_WR unreachable.

Verification
REQ-030 Defaults: write 0xDEADBEEF, bit_en 0xFFFFFFFF, addr 0x14 -> o_ram_we=4'b0010, word addr 1, byte_en 0xF at T+1, o_wr_ack at T+2.
REQ-031 Read addr 0x14 after REQ-030 write -> o_rd_ack at T+4, o_rd_data=0xDEADBEEF, o_oor=0.
REQ-032 RMW_EN defined, word 0xFFFFFFFF, write 0x00000000 bit_en 0x000000F0 -> o_wr_ack at T+5; readback 0xFFFFFF0F.
REQ-033 Read addr 0x80 (word 32 >= 32) -> o_rd_ack at T+1, o_oor=1, o_rd_data=0, o_ram_we=0.
REQ-034 Reset at T+2 of read -> no o_rd_ack; request at first post-reset cycle completes normally.
REQ-035 RAM_RD_LATENCY=1, NUM_BANKS=1: read -> o_rd_ack at T+3; i_req during busy ignored.
